// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: state encoding and
// parameter defaults used by mem_port_arbiter and anything that instantiates it.
package mem_arb_pkg;

  localparam int ADDR_W_DEF     = 32;
  localparam int DATA_W_DEF     = 32;
  localparam int STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one memory port.
// Data normally wins; a saturating streak counter forces a fetch grant to bound starvation.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy
);

  localparam int STREAK_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_MAX);

  arb_state_e          state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                i_ack_q, i_ack_d;
  logic                d_ack_q, d_ack_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                i_elig, d_elig;

  // A port whose ack is showing this cycle has just been served and must not be re-granted yet.
  assign i_elig = i_req && !i_ack_q;
  assign d_elig = d_req && !d_ack_q;

  always_comb begin
    state_d   = state_q;
    streak_d  = streak_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;

    case (state_q)
      IDLE: begin
        if (i_elig && (!d_elig || streak_q == STREAK_MAX)) begin
          state_d  = SERVE_I;
          addr_d   = i_addr;
          we_d     = 1'b0;
          streak_d = '0;
        end else if (d_elig) begin
          state_d = SERVE_D;
          addr_d  = d_addr;
          we_d    = d_we;
          wdata_d = d_wdata;
          if (!i_req) begin
            streak_d = '0;
          end else if (streak_q != STREAK_MAX) begin
            streak_d = streak_q + STREAK_W'(1);
          end
        end
      end
      SERVE_I: begin
        if (mem_ready) begin
          state_d   = IDLE;
          i_ack_d   = 1'b1;
          i_rdata_d = mem_rdata;
        end
      end
      SERVE_D: begin
        if (mem_ready) begin
          state_d = IDLE;
          d_ack_d = 1'b1;
          if (!we_q) begin
            d_rdata_d = mem_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      streak_q  <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      streak_q  <= streak_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Memory side comes purely from latched state; mem_addr/mem_wdata keep their last value while idle.
  assign busy      = (state_q != IDLE);
  assign mem_req   = busy;
  assign mem_we    = busy && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, directed corner cases,
// then random traffic compared cycle by cycle against a transaction-level model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req, d_req, d_we, mem_ready;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata, mem_rdata;
  logic          i_ack, d_ack, mem_req, mem_we, busy;
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: one outstanding transaction plus the visible result registers.
  typedef struct {
    bit            valid;
    bit            isData;
    logic [AW-1:0] addr;
    bit            we;
  } txn_t;

  txn_t          pend;
  int            mStreak;
  bit            mIAck, mDAck;
  logic [AW-1:0] mAddr;
  logic [DW-1:0] mWdata, mIRdata, mDRdata;

  typedef struct {
    logic rst; logic iReq; logic [AW-1:0] iAddr;
    logic dReq; logic [AW-1:0] dAddr; logic dWe; logic [DW-1:0] dWdata;
    logic rdy; logic [DW-1:0] rdata;
    logic eReq; logic [AW-1:0] eAddr; logic eWe; logic eIAck; logic eDAck;
    logic [DW-1:0] eIRdata; logic [DW-1:0] eDRdata;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic iReq, input logic [AW-1:0] iAddr,
                               input logic dReq, input logic [AW-1:0] dAddr, input logic dWe,
                               input logic [DW-1:0] dWdata, input logic rdy, input logic [DW-1:0] rdata);
    reset = rst; i_req = iReq; i_addr = iAddr;
    d_req = dReq; d_addr = dAddr; d_we = dWe; d_wdata = dWdata;
    mem_ready = rdy; mem_rdata = rdata;
  endtask

  task automatic modelEdge();
    bit iOk, dOk;
    if (reset) begin
      pend = '{valid: 1'b0, isData: 1'b0, addr: '0, we: 1'b0};
      mStreak = 0; mIAck = 0; mDAck = 0;
      mAddr = '0; mWdata = '0; mIRdata = '0; mDRdata = '0;
    end else if (pend.valid) begin
      mIAck = 0; mDAck = 0;
      if (mem_ready) begin
        if (pend.isData) begin
          mDAck = 1;
          if (!pend.we) mDRdata = mem_rdata;
        end else begin
          mIAck = 1;
          mIRdata = mem_rdata;
        end
        pend.valid = 0;
      end
    end else begin
      iOk = i_req && !mIAck;
      dOk = d_req && !mDAck;
      mIAck = 0; mDAck = 0;
      if (iOk && (!dOk || mStreak == SMAX)) begin
        pend = '{valid: 1'b1, isData: 1'b0, addr: i_addr, we: 1'b0};
        mAddr = i_addr;
        mStreak = 0;
      end else if (dOk) begin
        pend = '{valid: 1'b1, isData: 1'b1, addr: d_addr, we: d_we};
        mAddr = d_addr;
        mWdata = d_wdata;
        mStreak = i_req ? ((mStreak < SMAX) ? mStreak + 1 : SMAX) : 0;
      end
    end
  endtask

  task automatic compareModel();
    checkOutput("mem_req", mem_req, pend.valid);
    checkOutput("mem_we", mem_we, pend.valid && pend.we);
    checkOutput("mem_addr", mem_addr, mAddr);
    checkOutput("mem_wdata", mem_wdata, mWdata);
    checkOutput("i_ack", i_ack, mIAck);
    checkOutput("d_ack", d_ack, mDAck);
    checkOutput("i_rdata", i_rdata, mIRdata);
    checkOutput("d_rdata", d_rdata, mDRdata);
    checkOutput("busy", busy, pend.valid);
    checkOutput("streak", dut.streak_q, mStreak);
    checkOutput("ack_exclusive", i_ack & d_ack, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    modelEdge();
    #1;
    compareModel();
  endtask

  function automatic vec_t mkVec(logic rst, logic iReq, logic [AW-1:0] iAddr, logic dReq,
                                 logic [AW-1:0] dAddr, logic dWe, logic [DW-1:0] dWdata,
                                 logic rdy, logic [DW-1:0] rdata, logic eReq, logic [AW-1:0] eAddr,
                                 logic eWe, logic eIAck, logic eDAck,
                                 logic [DW-1:0] eIRdata, logic [DW-1:0] eDRdata);
    vec_t v;
    v = '{rst, iReq, iAddr, dReq, dAddr, dWe, dWdata, rdy, rdata,
          eReq, eAddr, eWe, eIAck, eDAck, eIRdata, eDRdata};
    return v;
  endfunction

  initial begin
    int dGrants;
    bit iGranted;

    // Lone fetch, then simultaneous store + fetch where the store goes first.
    vecs.push_back(mkVec(1, 0, 0,     0, 0,     0, 0,    0, 0,          0, 0,     0, 0, 0, 0,          0));
    vecs.push_back(mkVec(0, 1, 'h100, 0, 0,     0, 0,    0, 0,          1, 'h100, 0, 0, 0, 0,          0));
    vecs.push_back(mkVec(0, 1, 'h100, 0, 0,     0, 0,    1, 'hDEADBEEF, 0, 'h100, 0, 1, 0, 'hDEADBEEF, 0));
    vecs.push_back(mkVec(0, 0, 0,     0, 0,     0, 0,    0, 0,          0, 'h100, 0, 0, 0, 'hDEADBEEF, 0));
    vecs.push_back(mkVec(0, 1, 'h300, 1, 'h200, 1, 'h55, 0, 0,          1, 'h200, 1, 0, 0, 'hDEADBEEF, 0));
    vecs.push_back(mkVec(0, 1, 'h300, 1, 'h200, 1, 'h55, 1, 'h77,       0, 'h200, 0, 0, 1, 'hDEADBEEF, 0));
    vecs.push_back(mkVec(0, 1, 'h300, 0, 0,     0, 0,    0, 0,          1, 'h300, 0, 0, 0, 'hDEADBEEF, 0));
    vecs.push_back(mkVec(0, 1, 'h300, 0, 0,     0, 0,    1, 'h1234,     0, 'h300, 0, 1, 0, 'h1234,     0));
    vecs.push_back(mkVec(0, 0, 0,     0, 0,     0, 0,    0, 0,          0, 'h300, 0, 0, 0, 'h1234,     0));

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    foreach (vecs[k]) begin
      applyStimulus(vecs[k].rst, vecs[k].iReq, vecs[k].iAddr, vecs[k].dReq, vecs[k].dAddr,
                    vecs[k].dWe, vecs[k].dWdata, vecs[k].rdy, vecs[k].rdata);
      tick();
      checkOutput($sformatf("vec%0d_mem_req", k), mem_req, vecs[k].eReq);
      checkOutput($sformatf("vec%0d_mem_addr", k), mem_addr, vecs[k].eAddr);
      checkOutput($sformatf("vec%0d_mem_we", k), mem_we, vecs[k].eWe);
      checkOutput($sformatf("vec%0d_i_ack", k), i_ack, vecs[k].eIAck);
      checkOutput($sformatf("vec%0d_d_ack", k), d_ack, vecs[k].eDAck);
      checkOutput($sformatf("vec%0d_i_rdata", k), i_rdata, vecs[k].eIRdata);
      checkOutput($sformatf("vec%0d_d_rdata", k), d_rdata, vecs[k].eDRdata);
    end

    // Memory stall with the live address changing underneath.
    applyStimulus(0, 0, 0, 1, 'h400, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 1, 'h999, 0, 0, 0, 'h1111);
    for (int s = 0; s < 5; s++) begin
      tick();
      checkOutput("stall_addr", mem_addr, 'h400);
      checkOutput("stall_no_ack", d_ack, 0);
    end
    applyStimulus(0, 0, 0, 1, 'h999, 0, 0, 1, 'hCAFE);
    tick();
    checkOutput("stall_d_ack", d_ack, 1);
    checkOutput("stall_d_rdata", d_rdata, 'hCAFE);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("stall_ack_pulse", d_ack, 0);

    // Reset in the second serve cycle, colliding with mem_ready.
    applyStimulus(0, 0, 0, 1, 'h500, 1, 'hAA, 0, 0);
    tick();
    tick();
    applyStimulus(1, 0, 0, 1, 'h500, 1, 'hAA, 1, 'h77);
    tick();
    checkOutput("rst_mem_req", mem_req, 0);
    checkOutput("rst_d_ack", d_ack, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_wdata", mem_wdata, 0);
    checkOutput("rst_i_rdata", i_rdata, 0);
    checkOutput("rst_d_rdata", d_rdata, 0);
    applyStimulus(0, 0, 0, 1, 'h500, 1, 'hAA, 0, 0);
    tick();
    checkOutput("rst_regrant_req", mem_req, 1);
    checkOutput("rst_regrant_addr", mem_addr, 'h500);
    applyStimulus(0, 0, 0, 1, 'h500, 1, 'hAA, 1, 0);
    tick();
    checkOutput("rst_regrant_ack", d_ack, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Fetch held through its ack cycle: no grant then, grant the cycle after.
    applyStimulus(0, 1, 'h600, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 1, 'h600, 0, 0, 0, 0, 1, 'h42);
    tick();
    checkOutput("filter_i_ack", i_ack, 1);
    applyStimulus(0, 1, 'h600, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("filter_no_dup", mem_req, 0);
    tick();
    checkOutput("filter_regrant", mem_req, 1);
    applyStimulus(0, 1, 'h600, 0, 0, 0, 0, 1, 'h43);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Starvation: fetch withdrawn only during each d_ack cycle so data keeps winning until the cap.
    dGrants = 0;
    iGranted = 0;
    for (int g = 0; g < 8 && !iGranted; g++) begin
      applyStimulus(0, 1, 'h700, 1, 'h800 + g, 0, 0, 0, 0);
      tick();
      if (mem_addr == 'h700) begin
        iGranted = 1;
      end else begin
        dGrants++;
        applyStimulus(0, 1, 'h700, 1, 'h800 + g, 0, 0, 1, g);
        tick();
        applyStimulus(0, 0, 'h700, 1, 'h800 + g, 0, 0, 0, 0);
        tick();
      end
    end
    checkOutput("starve_d_grants", dGrants, SMAX);
    checkOutput("starve_i_granted", iGranted, 1);
    checkOutput("starve_streak_clear", dut.streak_q, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 'h99);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Random traffic against the model.
    for (int r = 0; r < 3000; r++) begin
      applyStimulus($urandom_range(0, 99) == 0,
                    $urandom_range(0, 3) != 0, $urandom(),
                    $urandom_range(0, 3) != 0, $urandom(), 1'($urandom_range(0, 1)), $urandom(),
                    $urandom_range(0, 2) != 0, $urandom());
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
